io_ctrl: RTL and testbench
==========================

Name: io_ctrl

Overview:
- Memory-mapped IO peripheral block of the single-cycle on-board CPU.
- Sits directly downstream of the bus decoder, which drives io_en, io_addr, io_we and io_write_data; io_ctrl returns io_read_data to it.
- Owns the board peripherals: 8-digit scanned seven-segment display, 24 LEDs, 24 switches and 5 debounced buttons.
- Reads are combinational (single-cycle CPU). Writes take effect at the clock edge.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit is lit during display scan; minimum 2.
- DEB_CYCLES, 1000000: consecutive stable cycles required before a button change is accepted; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- io_en  input  1  bus addresses the IO region.
- io_we  input  1  write strobe; only meaningful when io_en=1.
- io_addr  input  12  offset within the IO page.
- io_write_data  input  32  write data.
- io_read_data  output  32  read data.
- sw  input  24  raw switch pins, asynchronous.
- btn  input  5  raw button pins, asynchronous, active-high.
- led  output  24  LED drive, active-high.
- dig_en  output  8  digit select, active-low, one-cold.
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Address map (io_addr):
  - 0x000 TUBE: R/W 32-bit display data; nibble k is shown on digit k.
  - 0x060 LED: R/W; bits[23:0] are used, upper bits read 0.
  - 0x070 SW: read-only, returns {8'h0, sw_sync}.
  - 0x078 BTN: read-only, returns {27'h0, btn_db}.
- Write rule: register updates at posedge when io_en & io_we and the address matches a R/W location.
  - Writes to read-only or unmapped offsets are ignored.
  - Upper 8 bits of an LED write are discarded.
- Read rule (combinational):
  - io_en=0 -> 0.
  - Unmapped offset -> 0.
  - Read in the same cycle as a write to the same register returns the old value.
- Switch sync: two-flop synchroniser, so sw_sync lags sw by 2 cycles.
- Button sync: same two-flop synchroniser feeding the debounce stage.
- Debounce, one counter per button:
  - If synced input == btn_db, counter clears.
  - Otherwise the counter increments; when it reaches DEB_CYCLES-1, btn_db takes the new value and the counter clears.
  - Any glitch back to btn_db before that point clears the counter.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index (3-bit) increments, 7 wraps to 0.
  - dig_en = ~(1 << index).
  - seg = active-low hex decode of TUBE[4*index+3 : 4*index], dp always off (1).
  - The hex decode covers 0-F.
  - seg/dig_en are registered together so they change on the same edge (no ghosting).
- Reset values, sync to rst:
  - TUBE, LED = 0; led=0.
  - Synchronisers, btn_db and counters = 0.
  - index=0; dig_en=8'hFF; seg=8'hFF (blank for one cycle, then digit 0 shows "0").
- Reset mid-scan or mid-debounce: all state returns to reset values on the next edge; a pending button change is lost.
- Simultaneous write to TUBE and scan advance: the new digit uses the updated TUBE value from the following edge. No tearing requirement beyond that.

Decomposition:
- Shared constants header:
  - IO page base.
  - Offsets TUBE_ADDR, LED_ADDR, SW_ADDR, BTN_ADDR.
  - READ/WRITE encodings.
- Sub-module seg_decoder: combinational 4-bit hex -> active-low 7-segment pattern.
- Debounce is written as a generate loop inside io_ctrl.

Test Plan (SCAN_DIV=4, DEB_CYCLES=8):
- Reset: after rst high 2 cycles -> led=0, dig_en=FF, io_read_data=0 for each mapped address; 1 cycle later dig_en=FE, seg=C0 ("0").
- Write LED: io_en=1, io_we=1, addr 0x060, data 0xFFA5A5A5 -> led=A5A5A5 next cycle; read 0x060 returns 0x00A5A5A5.
- Write TUBE 0x89ABCDEF:
  - dig_en steps FE, FD, FB ... 7F, 4 cycles each, then FE again.
  - seg on digit0 = 8E ("F"); digit7 = 80 ("8").
- Switches: sw=0x123456 -> read 0x070 returns 0x00123456 from the 3rd edge onward; io_en=0 with the same address returns 0.
- Button debounce:
  - btn[2] high 5 cycles then low -> BTN reads 0.
  - btn[2] held high -> BTN reads 0x4 after 2+8 cycles.
- Ignored accesses:
  - Write to 0x070 or 0x100 -> no register changes.
  - Read 0x100 -> 0.
  - rst asserted mid-scan -> dig_en=FF next cycle.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared constants for the memory-mapped IO block.
//   IO_BASE      - CPU address of the IO page (io_addr is the offset within it)
//   *_ADDR       - register offsets inside the IO page
//   io_op_e      - bus access direction as carried on io_we
//   digit_sel    - active-low one-cold digit enable for a 3-bit digit index
package io_ctrl_pkg;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;

    localparam logic [11:0] TUBE_ADDR = 12'h000;
    localparam logic [11:0] LED_ADDR  = 12'h060;
    localparam logic [11:0] SW_ADDR   = 12'h070;
    localparam logic [11:0] BTN_ADDR  = 12'h078;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } io_op_e;

    function automatic logic [7:0] digit_sel(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// io_ctrl_if: CPU-side IO bus between the bus decoder and io_ctrl.
//   io_en         - access targets the IO page
//   io_we         - write strobe (valid with io_en)
//   io_addr       - 12-bit offset within the IO page
//   io_write_data - write data
//   io_read_data  - combinational read data returned by io_ctrl
// master: bus decoder side; slave: io_ctrl side.
interface io_ctrl_if;

    logic        io_en;
    logic        io_we;
    logic [11:0] io_addr;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;

    modport master (
        output io_en,
        output io_we,
        output io_addr,
        output io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_en,
        input  io_we,
        input  io_addr,
        input  io_write_data,
        output io_read_data
    );

endinterface

// File: rtl/io_ctrl_seg_decoder.sv
// io_ctrl_seg_decoder: combinational hex digit to seven-segment pattern.
//   hex   - 4-bit value 0-F
//   seg_n - segments {g,f,e,d,c,b,a}, active-low (0 = lit)
module io_ctrl_seg_decoder (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        unique case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped board peripherals for the single-cycle CPU.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - io_ctrl_if slave: io_en/io_we/io_addr/io_write_data in, io_read_data out
//   sw       - 24 raw switch pins (asynchronous)
//   btn      - 5 raw button pins (asynchronous, active-high)
//   led      - 24 LED drives, active-high
//   dig_en   - 8 digit selects, active-low one-cold
//   seg      - segments {dp,g,f,e,d,c,b,a}, active-low
// Registers: TUBE (0x000, R/W), LED (0x060, R/W), SW (0x070, RO), BTN (0x078, RO).
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    io_ctrl_if.slave    bus,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);

    logic [31:0]       tube_q;
    logic [23:0]       led_q;
    logic [23:0]       sw_s1_q, sw_s2_q;
    logic [4:0]        btn_s1_q, btn_s2_q;
    logic [4:0]        btn_db;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [2:0]        idx_q;
    logic [7:0]        dig_en_q, seg_q;
    logic [6:0]        seg_pat;
    logic              wr, scan_wrap;

    assign wr = bus.io_en && (io_op_e'(bus.io_we) == WRITE);

    // Register file writes; read-only and unmapped offsets fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            tube_q <= '0;
            led_q  <= '0;
        end else if (wr) begin
            if (bus.io_addr == TUBE_ADDR) tube_q <= bus.io_write_data;
            if (bus.io_addr == LED_ADDR)  led_q  <= bus.io_write_data[23:0];
        end
    end

    // Combinational read: a same-cycle write is not yet visible.
    always_comb begin
        bus.io_read_data = '0;
        if (bus.io_en) begin
            case (bus.io_addr)
                TUBE_ADDR: bus.io_read_data = tube_q;
                LED_ADDR:  bus.io_read_data = {8'h0, led_q};
                SW_ADDR:   bus.io_read_data = {8'h0, sw_s2_q};
                BTN_ADDR:  bus.io_read_data = {27'h0, btn_db};
                default:   bus.io_read_data = '0;
            endcase
        end
    end

    // Two-flop synchronisers for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Per-button debounce: accept a change only after DEB_CYCLES differing samples in a row.
    for (genvar i = 0; i < 5; i++) begin : g_deb
        logic [DEB_W-1:0] cnt_q;
        logic             db_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (btn_s2_q[i] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                cnt_q <= '0;
                db_q  <= btn_s2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign btn_db[i] = db_q;
    end

    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    io_ctrl_seg_decoder u_seg_decoder (
        .hex   (tube_q[{idx_q, 2'b00} +: 4]),
        .seg_n (seg_pat)
    );

    // dig_en and seg are captured on the same edge from the same index so a digit
    // never shows its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
            if (scan_wrap) idx_q <= idx_q + 3'd1;
            dig_en_q   <= digit_sel(idx_q);
            seg_q      <= {1'b1, seg_pat};
        end
    end

    assign led    = led_q;
    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: self-checking bench for io_ctrl (SCAN_DIV=4, DEB_CYCLES=8).
// A behavioural model derives every expected output from the cycle count since reset,
// the register contents written over the bus and the history of pin samples.
module tb_io_ctrl;
    import io_ctrl_pkg::*;

    localparam int unsigned SCAN = 4;
    localparam int unsigned DEB  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en, seg;

    io_ctrl_if bus_if ();

    io_ctrl #(
        .SCAN_DIV   (SCAN),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .sw     (sw),
        .btn    (btn),
        .led    (led),
        .dig_en (dig_en),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Active-low {dp,g,f,e,d,c,b,a} patterns for 0-F with dp off.
    logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // ---------------- reference model ----------------
    logic [31:0] m_tube;
    logic [23:0] m_led;
    logic [23:0] m_sw_hist [2];
    logic [4:0]  m_btn_hist [2];
    logic [4:0]  m_db;
    int          m_run [5];
    int          m_cyc;
    logic [7:0]  m_dig, m_seg;

    always @(posedge clk) begin
        if (rst) begin
            m_tube <= '0;
            m_led  <= '0;
            m_sw_hist[0] <= '0;
            m_sw_hist[1] <= '0;
            m_btn_hist[0] <= '0;
            m_btn_hist[1] <= '0;
            m_db   <= '0;
            for (int i = 0; i < 5; i++) m_run[i] <= 0;
            m_cyc  <= 0;
            m_dig  <= 8'hFF;
            m_seg  <= 8'hFF;
        end else begin
            // Digit shown after edge n+1 is the one selected n edges after reset.
            m_dig <= ~(8'h01 << ((m_cyc / SCAN) % 8));
            m_seg <= seg_lut[(m_tube >> (4 * ((m_cyc / SCAN) % 8))) & 32'hF];
            m_cyc <= m_cyc + 1;
            if (bus_if.io_en && bus_if.io_we && bus_if.io_addr == TUBE_ADDR)
                m_tube <= bus_if.io_write_data;
            if (bus_if.io_en && bus_if.io_we && bus_if.io_addr == LED_ADDR)
                m_led <= bus_if.io_write_data[23:0];
            m_sw_hist[0]  <= sw;
            m_sw_hist[1]  <= m_sw_hist[0];
            m_btn_hist[0] <= btn;
            m_btn_hist[1] <= m_btn_hist[0];
            // Length of the current run of samples disagreeing with the accepted level.
            for (int i = 0; i < 5; i++) begin
                if (m_btn_hist[1][i] == m_db[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] + 1 >= DEB) begin
                    m_db[i]  <= m_btn_hist[1][i];
                    m_run[i] <= 0;
                end else begin
                    m_run[i] <= m_run[i] + 1;
                end
            end
        end
    end

    function automatic logic [31:0] m_read(input logic en, input logic [11:0] addr);
        if (!en) return 32'h0;
        if (addr == TUBE_ADDR) return m_tube;
        if (addr == LED_ADDR)  return {8'h0, m_led};
        if (addr == SW_ADDR)   return {8'h0, m_sw_hist[1]};
        if (addr == BTN_ADDR)  return {27'h0, m_db};
        return 32'h0;
    endfunction

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_rdata", bus_if.io_read_data, m_read(bus_if.io_en, bus_if.io_addr));
            check("model_led", {8'h0, led}, {8'h0, m_led});
            check("model_dig_en", {24'h0, dig_en}, {24'h0, m_dig});
            check("model_seg", {24'h0, seg}, {24'h0, m_seg});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [11:0] addr,
                         input logic [31:0] wdata);
        bus_if.io_en         = en;
        bus_if.io_we         = we;
        bus_if.io_addr       = addr;
        bus_if.io_write_data = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;   // read data before the edge
        logic [23:0] exp_led;  // led before the edge
    } vec_t;

    vec_t vecs [17];

    logic [7:0] scan_seg_exp [8];
    logic [11:0] addr_pool [5];
    int hold;

    initial begin
        vecs = '{
            '{1'b1, 1'b1, 12'h060, 32'hFFA5_A5A5, 32'h0000_0000, 24'h000000},
            '{1'b1, 1'b0, 12'h060, 32'h0,         32'h00A5_A5A5, 24'hA5A5A5},
            '{1'b0, 1'b0, 12'h060, 32'h0,         32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b1, 12'h070, 32'hFFFF_FFFF, 32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h070, 32'h0,         32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b1, 12'h100, 32'h1234_5678, 32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h100, 32'h0,         32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h078, 32'h0,         32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b1, 12'h000, 32'hDEAD_BEEF, 32'h0000_0000, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h000, 32'h0,         32'hDEAD_BEEF, 24'hA5A5A5},
            '{1'b1, 1'b1, 12'h060, 32'h1234_5678, 32'h00A5_A5A5, 24'hA5A5A5},
            '{1'b1, 1'b0, 12'h060, 32'h0,         32'h0034_5678, 24'h345678},
            '{1'b1, 1'b0, 12'h064, 32'h0,         32'h0000_0000, 24'h345678},
            '{1'b0, 1'b1, 12'h060, 32'hFFFF_FFFF, 32'h0000_0000, 24'h345678},
            '{1'b1, 1'b0, 12'h060, 32'h0,         32'h0034_5678, 24'h345678},
            '{1'b1, 1'b0, 12'h000, 32'h0,         32'hDEAD_BEEF, 24'h345678}
        };
        // TUBE = 0x89ABCDEF: digit k shows nibble k.
        scan_seg_exp = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        addr_pool = '{TUBE_ADDR, LED_ADDR, SW_ADDR, BTN_ADDR, 12'h100};

        sw  = '0;
        btn = '0;
        do_reset();

        // Reset state, still inside the blank cycle.
        rst = 1'b1;
        tick();
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("rst_seg", {24'h0, seg}, 32'hFF);
        foreach (addr_pool[i]) begin
            drive(1'b1, 1'b0, addr_pool[i], 32'h0);
            #1;
            check("rst_read", bus_if.io_read_data, 32'h0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 12'h0, 32'h0);
        chk_on = 1'b1;
        tick();
        check("first_dig_en", {24'h0, dig_en}, 32'hFE);
        check("first_seg", {24'h0, seg}, 32'hC0);

        // Register access table.
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            check("vec_rdata", bus_if.io_read_data, vecs[i].exp_rd);
            check("vec_led", {8'h0, led}, {8'h0, vecs[i].exp_led});
            tick();
        end

        // Scan sequence: TUBE written on the first edge after reset.
        do_reset();
        drive(1'b1, 1'b1, TUBE_ADDR, 32'h89AB_CDEF);
        tick();
        drive(1'b0, 1'b0, 12'h0, 32'h0);
        check("scan_e1_dig", {24'h0, dig_en}, 32'hFE);
        check("scan_e1_seg", {24'h0, seg}, 32'hC0);
        for (int t = 2; t <= 34; t++) begin
            tick();
            if (t % 4 == 2 && t < 34) begin
                check("scan_dig", {24'h0, dig_en}, {24'h0, ~(8'h01 << ((t - 2) / 4))});
                check("scan_seg", {24'h0, seg}, {24'h0, scan_seg_exp[(t - 2) / 4]});
            end
        end
        check("scan_wrap_dig", {24'h0, dig_en}, 32'hFE);
        check("scan_wrap_seg", {24'h0, seg}, 32'h8E);

        // Reset mid-scan.
        tick();
        rst = 1'b1;
        tick();
        check("midrst_dig", {24'h0, dig_en}, 32'hFF);
        check("midrst_seg", {24'h0, seg}, 32'hFF);
        drive(1'b1, 1'b0, TUBE_ADDR, 32'h0);
        #1;
        check("midrst_tube", bus_if.io_read_data, 32'h0);
        rst = 1'b0;
        tick();
        check("midrst_rel_dig", {24'h0, dig_en}, 32'hFE);
        check("midrst_rel_seg", {24'h0, seg}, 32'hC0);

        // Switch synchroniser.
        sw = 24'h123456;
        drive(1'b1, 1'b0, SW_ADDR, 32'h0);
        tick();
        check("sw_e1", bus_if.io_read_data, 32'h0);
        tick();
        tick();
        check("sw_e3", bus_if.io_read_data, 32'h0012_3456);
        drive(1'b0, 1'b0, SW_ADDR, 32'h0);
        #1;
        check("sw_no_en", bus_if.io_read_data, 32'h0);

        // Debounce: short pulse rejected, held press accepted after 2+8 edges.
        drive(1'b1, 1'b0, BTN_ADDR, 32'h0);
        btn = 5'b00100;
        repeat (5) tick();
        btn = 5'b00000;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("btn_glitch", bus_if.io_read_data, 32'h0);
        end
        btn = 5'b00100;
        repeat (9) tick();
        check("btn_e9", bus_if.io_read_data, 32'h0);
        tick();
        check("btn_e10", bus_if.io_read_data, 32'h4);
        btn = 5'b00000;
        repeat (10) tick();
        check("btn_release", bus_if.io_read_data, 32'h0);

        // Randomised traffic against the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
            if (hold == 0) begin
                btn  = 5'($urandom);
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            drive($urandom_range(0, 3) != 0, 1'($urandom),
                  ($urandom_range(0, 5) == 5) ? 12'($urandom) : addr_pool[$urandom_range(0, 4)],
                  $urandom);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
